// File: rtl/cr_kme_fifo_pstall.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_pstall
//   First-word-fall-through FIFO with a programmable upstream stall level,
//   overflow/underflow error pulses and an optional high-water mark.
//
//   Optional feature macro: CR_KME_FIFO_HWM_EN
//     defined   -> hwm tracks the peak occupancy; hwm_clr reloads it
//     undefined -> hwm is tied to 0 and hwm_clr is ignored (no hwm flops)
//
// Parameters
//   DATA_WIDTH      entry width in bits (1..512)
//   DEPTH           entry count, power of two (2..1024)
//   STALL_THRESHOLD free-slot level at or below which fifo_in_stall asserts
//
// Ports
//   clk                     sole clock, rising edge
//   rst                     synchronous active-high reset, beats everything
//   clear                   synchronous flush of pointers and count
//   fifo_in / fifo_in_valid write data and write request
//   fifo_in_stall_override  forces fifo_in_stall high
//   fifo_out_ack            read acknowledge (pop when fifo_out_valid)
//   hwm_clr                 reloads hwm with the next occupancy
//   fifo_in_stall           upstream hold-off, from the registered count only
//   fifo_out / _valid       head entry, no read latency
//   used_slots / free_slots occupancy and DEPTH - occupancy
//   fifo_overflow           one-cycle pulse after a push into a full FIFO
//   fifo_underflow          one-cycle pulse after an ack on an empty FIFO
//   hwm                     peak occupancy
// ---------------------------------------------------------------------------
module cr_kme_fifo_pstall #(
    parameter int unsigned DATA_WIDTH      = 132,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned STALL_THRESHOLD = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [DATA_WIDTH-1:0]     fifo_in,
    input  logic                      fifo_in_valid,
    input  logic                      fifo_in_stall_override,
    input  logic                      fifo_out_ack,
    input  logic                      hwm_clr,
    output logic                      fifo_in_stall,
    output logic [DATA_WIDTH-1:0]     fifo_out,
    output logic                      fifo_out_valid,
    output logic [$clog2(DEPTH):0]    used_slots,
    output logic [$clog2(DEPTH):0]    free_slots,
    output logic                      fifo_overflow,
    output logic                      fifo_underflow,
    output logic [$clog2(DEPTH):0]    hwm
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rptr;
    logic [AW-1:0]         r_wptr;
    logic [CW-1:0]         r_used;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_used_nxt;

    assign w_full  = (r_used == CW'(DEPTH));
    assign w_empty = (r_used == '0);

    // Fullness is judged on the count at the start of the cycle, so a push
    // into a full FIFO is dropped even when a pop happens in the same cycle.
    assign w_push = fifo_in_valid & ~w_full;
    assign w_pop  = fifo_out_ack  & ~w_empty;

    always_comb begin
        w_used_nxt = r_used;
        if (clear) begin
            w_used_nxt = '0;
        end else begin
            w_used_nxt = r_used + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_used <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else if (clear) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_used <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_used <= w_used_nxt;
            r_ovf  <= fifo_in_valid & w_full;
            r_unf  <= fifo_out_ack & w_empty;
        end
    end

    // Storage is never reset or zeroed; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= fifo_in;
        end
    end

    assign fifo_out       = r_mem[r_rptr];
    assign fifo_out_valid = ~w_empty;
    assign used_slots     = r_used;
    assign free_slots     = CW'(DEPTH) - r_used;
    assign fifo_overflow  = r_ovf;
    assign fifo_underflow = r_unf;
    assign fifo_in_stall  = fifo_in_stall_override |
                            (free_slots <= CW'(STALL_THRESHOLD));

`ifdef CR_KME_FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    // Tracks the post-update occupancy; a clear drives that to 0, which
    // leaves the peak untouched unless hwm_clr is also asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm <= '0;
        end else if (hwm_clr) begin
            r_hwm <= w_used_nxt;
        end else if (w_used_nxt > r_hwm) begin
            r_hwm <= w_used_nxt;
        end
    end

    assign hwm = r_hwm;
`else
    logic w_unused_hwm_clr;

    assign w_unused_hwm_clr = hwm_clr;
    assign hwm              = '0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_pstall.sv
module tb_cr_kme_fifo_pstall;

    localparam int DW    = 132;
    localparam int DEPTH = 16;
    localparam int THR   = 2;

    logic          clk = 1'b0;
    logic          rst, clear, fifo_in_valid, ovr, fifo_out_ack, hwm_clr;
    logic [DW-1:0] fifo_in;
    logic          fifo_in_stall, fifo_out_valid, fifo_overflow, fifo_underflow;
    logic [DW-1:0] fifo_out;
    logic [4:0]    used_slots, free_slots, hwm;

    int n_pass = 0;
    int n_checks = 0;

    // Reference model: a queue of entries plus expected pulse flags.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    int            m_hwm, e_hwm;

    cr_kme_fifo_pstall #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .STALL_THRESHOLD (THR)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .clear                  (clear),
        .fifo_in                (fifo_in),
        .fifo_in_valid          (fifo_in_valid),
        .fifo_in_stall_override (ovr),
        .fifo_out_ack           (fifo_out_ack),
        .hwm_clr                (hwm_clr),
        .fifo_in_stall          (fifo_in_stall),
        .fifo_out               (fifo_out),
        .fifo_out_valid         (fifo_out_valid),
        .used_slots             (used_slots),
        .free_slots             (free_slots),
        .fifo_overflow          (fifo_overflow),
        .fifo_underflow         (fifo_underflow),
        .hwm                    (hwm)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Drive one cycle of inputs, advance the model, return #1 after the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit a,
                        input bit c, input bit hc, input bit r);
        int sz;
        @(negedge clk);
        fifo_in_valid = v; fifo_in = d; fifo_out_ack = a;
        clear = c; hwm_clr = hc; rst = r;
        @(posedge clk);
        sz = q.size();
        if (r) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_hwm = 0;
        end else if (c) begin
            q.delete(); m_ovf = 0; m_unf = 0;
            if (hc) m_hwm = 0;
        end else begin
            m_ovf = v && (sz == DEPTH);
            m_unf = a && (sz == 0);
            if (a && sz > 0) void'(q.pop_front());
            if (v && sz < DEPTH) q.push_back(d);
            if (hc) m_hwm = q.size();
            else if (q.size() > m_hwm) m_hwm = q.size();
        end
`ifdef CR_KME_FIFO_HWM_EN
        e_hwm = m_hwm;
`else
        e_hwm = 0;
`endif
        #1;
    endtask

    task automatic test_reset();
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        n_checks++; if (used_slots !== 5'd0) $display("FAIL reset_used: got %0d expected 0", used_slots); else n_pass++;
        n_checks++; if (free_slots !== 5'd16) $display("FAIL reset_free: got %0d expected 16", free_slots); else n_pass++;
        n_checks++; if (fifo_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", fifo_out_valid); else n_pass++;
        n_checks++; if ({fifo_overflow, fifo_underflow} !== 2'b00) $display("FAIL reset_err: got %b%b expected 00", fifo_overflow, fifo_underflow); else n_pass++;
        n_checks++; if (hwm !== 5'd0) $display("FAIL reset_hwm: got %0d expected 0", hwm); else n_pass++;
        n_checks++; if (fifo_in_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", fifo_in_stall); else n_pass++;
    endtask

    task automatic test_fill_stall();
        bit exp_stall;
        for (int i = 1; i <= 14; i++) begin
            step(1, DW'(i), 0, 0, 0, 0);
            exp_stall = (DEPTH - q.size()) <= THR;
            n_checks++; if (fifo_in_stall !== exp_stall) $display("FAIL fill_stall[%0d]: got %b expected %b", i, fifo_in_stall, exp_stall); else n_pass++;
        end
        n_checks++; if (used_slots !== 5'd14 || free_slots !== 5'd2) $display("FAIL fill_count: got used %0d free %0d expected 14/2", used_slots, free_slots); else n_pass++;
        n_checks++; if (fifo_out_valid !== 1'b1 || fifo_out !== DW'(1)) $display("FAIL fill_head: got valid %b data %0h expected 1/1", fifo_out_valid, fifo_out); else n_pass++;
    endtask

    task automatic test_overflow();
        step(1, rand_data(), 0, 0, 0, 0);
        step(1, rand_data(), 0, 0, 0, 0);
        n_checks++; if (used_slots !== 5'd16 || fifo_in_stall !== 1'b1) $display("FAIL ovf_full: got used %0d stall %b expected 16/1", used_slots, fifo_in_stall); else n_pass++;
        step(1, DW'('hAA), 1, 0, 0, 0);
        n_checks++; if (fifo_overflow !== 1'b1) $display("FAIL ovf_pulse: got %b expected 1", fifo_overflow); else n_pass++;
        n_checks++; if (used_slots !== 5'd15) $display("FAIL ovf_used: got %0d expected 15", used_slots); else n_pass++;
        step(0, '0, 0, 0, 0, 0);
        n_checks++; if (fifo_overflow !== 1'b0) $display("FAIL ovf_once: got %b expected 0", fifo_overflow); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (fifo_out === DW'('hAA) || fifo_out !== q[0]) $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, fifo_out, q[0]); else n_pass++;
            step(0, '0, 1, 0, 0, 0);
        end
        n_checks++; if (used_slots !== 5'd0 || fifo_out_valid !== 1'b0) $display("FAIL ovf_empty: got used %0d valid %b expected 0/0", used_slots, fifo_out_valid); else n_pass++;
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            step(0, '0, 1, 0, 0, 0);
            n_checks++; if (fifo_underflow !== 1'b1 || used_slots !== 5'd0) $display("FAIL unf_pulse[%0d]: got unf %b used %0d expected 1/0", i, fifo_underflow, used_slots); else n_pass++;
        end
        step(0, '0, 0, 0, 0, 0);
        n_checks++; if (fifo_underflow !== 1'b0) $display("FAIL unf_end: got %b expected 0", fifo_underflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1, rand_data(), 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, rand_data(), 1, 0, 0, 0);
            n_checks++; if (used_slots !== 5'd8) $display("FAIL b2b_used[%0d]: got %0d expected 8", i, used_slots); else n_pass++;
            n_checks++; if (fifo_out !== q[0]) $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, fifo_out, q[0]); else n_pass++;
        end
    endtask

    task automatic test_clear();
        step(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, rand_data(), 0, 0, 0, 0);
        step(1, rand_data(), 0, 1, 0, 0);
        n_checks++; if (used_slots !== 5'd0 || fifo_out_valid !== 1'b0) $display("FAIL clr_state: got used %0d valid %b expected 0/0", used_slots, fifo_out_valid); else n_pass++;
        n_checks++; if ({fifo_overflow, fifo_underflow} !== 2'b00) $display("FAIL clr_err: got %b%b expected 00", fifo_overflow, fifo_underflow); else n_pass++;
        ovr = 1'b1; #1;
        n_checks++; if (fifo_in_stall !== 1'b1) $display("FAIL ovr_on: got %b expected 1", fifo_in_stall); else n_pass++;
        ovr = 1'b0; #1;
        n_checks++; if (fifo_in_stall !== 1'b0) $display("FAIL ovr_off: got %b expected 0", fifo_in_stall); else n_pass++;
    endtask

    task automatic test_hwm();
        step(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) step(1, rand_data(), 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, 0);
        n_checks++; if (used_slots !== 5'd3 || hwm !== 5'(e_hwm)) $display("FAIL hwm_peak: got used %0d hwm %0d expected 3/%0d", used_slots, hwm, e_hwm); else n_pass++;
        step(0, '0, 0, 0, 1, 0);
        n_checks++; if (hwm !== 5'(e_hwm)) $display("FAIL hwm_clr: got %0d expected %0d", hwm, e_hwm); else n_pass++;
        step(0, '0, 0, 1, 0, 0);
        n_checks++; if (hwm !== 5'(e_hwm)) $display("FAIL hwm_keep: got %0d expected %0d", hwm, e_hwm); else n_pass++;
    endtask

    task automatic test_random();
        bit v, a, c, hc, r, exp_stall;
        for (int i = 0; i < 400; i++) begin
            v  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            a  = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 47) == 0);
            hc = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 149) == 0);
            step(v, rand_data(), a, c, hc, r);
            exp_stall = (DEPTH - q.size()) <= THR;
            n_checks++;
            if (used_slots !== 5'(q.size()) || free_slots !== 5'(DEPTH - q.size()) ||
                fifo_out_valid !== (q.size() != 0) || fifo_in_stall !== exp_stall)
                $display("FAIL rnd_state[%0d]: got used %0d free %0d valid %b stall %b expected used %0d stall %b",
                         i, used_slots, free_slots, fifo_out_valid, fifo_in_stall, q.size(), exp_stall);
            else n_pass++;
            n_checks++;
            if (fifo_overflow !== m_ovf || fifo_underflow !== m_unf || hwm !== 5'(e_hwm))
                $display("FAIL rnd_flags[%0d]: got ovf %b unf %b hwm %0d expected %b %b %0d",
                         i, fifo_overflow, fifo_underflow, hwm, m_ovf, m_unf, e_hwm);
            else n_pass++;
            if (q.size() != 0) begin
                n_checks++;
                if (fifo_out !== q[0]) $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, fifo_out, q[0]); else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; fifo_in_valid = 1'b0; ovr = 1'b0;
        fifo_out_ack = 1'b0; hwm_clr = 1'b0; fifo_in = '0;
        test_reset();
        test_fill_stall();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_clear();
        test_hwm();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cr_kme_fifo_pstall.md
CR_KME_FIFO_PSTALL -- requirements
Module: cr_kme_fifo_pstall

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 132, entry width in bits (1..512).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, 2..1024.
REQ-003 SHALL have parameter STALL_THRESHOLD, default 0, free-slot level at or below which stall asserts; 0..DEPTH-1.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port clear  input  1  synchronous flush.
REQ-007 SHALL have port fifo_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port fifo_in_valid  input  1  write request.
REQ-009 SHALL have port fifo_in_stall_override  input  1  forces fifo_in_stall high.
REQ-010 SHALL have port fifo_out_ack  input  1  read acknowledge.
REQ-011 SHALL have port hwm_clr  input  1  clears high-water mark.
REQ-012 SHALL have port fifo_in_stall  output  1  upstream hold-off.
REQ-013 SHALL have port fifo_out  output  DATA_WIDTH  head entry.
REQ-014 SHALL have port fifo_out_valid  output  1  head entry valid.
REQ-015 SHALL have ports used_slots and free_slots  output  log2(DEPTH)+1 each  occupancy and DEPTH-occupancy.
REQ-016 SHALL have ports fifo_overflow and fifo_underflow  output  1 each  error pulses.
REQ-017 SHALL have port hwm  output  log2(DEPTH)+1  peak occupancy.

Function
REQ-018 SHALL be first-word-fall-through: fifo_out_valid = (used_slots != 0); fifo_out shows the oldest entry whenever valid, with no read latency.
REQ-019 SHALL pop on a cycle where fifo_out_valid & fifo_out_ack; the next entry appears the following cycle.
REQ-020 SHALL accept a push when fifo_in_valid and used_slots < DEPTH, measured at the start of the cycle; the data becomes visible on fifo_out one cycle after the write at the earliest.
REQ-021 SHALL drop a push when used_slots == DEPTH, even with a simultaneous pop, and pulse fifo_overflow high for exactly one cycle, the cycle after.
REQ-022 SHALL pulse fifo_underflow for one cycle, the cycle after fifo_out_ack is high while fifo_out_valid is low; state unchanged.
REQ-023 SHALL leave used_slots unchanged on a simultaneous accepted push and pop; wrap read and write pointers modulo DEPTH.
REQ-024 SHALL drive fifo_in_stall = fifo_in_stall_override | (free_slots <= STALL_THRESHOLD), combinational from the registered count only (no fifo_in_valid path).
REQ-025 SHALL keep free_slots = DEPTH - used_slots at all times; used_slots SHALL never exceed DEPTH.
REQ-026 SHALL flush on clear: pointers and count go to 0 next cycle; clear beats push, pop, overflow and underflow in the same cycle; storage contents are not zeroed.

Reset
REQ-027 SHALL, while rst is high at a clock edge, set pointers and used_slots to 0, free_slots to DEPTH, fifo_out_valid, fifo_overflow, fifo_underflow and hwm to 0; fifo_out is don't-care.
REQ-028 SHALL have rst override clear, hwm_clr and all traffic; reset mid-stream discards all entries; storage RAM is not reset.

Configuration
REQ-029 SHALL, with CR_KME_FIFO_HWM_EN defined, register hwm = max(hwm, next used_slots) every cycle; hwm_clr loads the next used_slots; clear leaves hwm unchanged.
REQ-030 SHALL, without CR_KME_FIFO_HWM_EN, tie hwm to 0, ignore hwm_clr and contain no hwm flops; all other behaviour is identical.

Verification (DEPTH=16, STALL_THRESHOLD=2, DATA_WIDTH=132)
REQ-031 SHALL cover: reset, then push 0x1..0xE one per cycle with ack low -> stall rises once used=14/free=2; used=14, valid=1, fifo_out=0x1.
REQ-032 SHALL cover: fill to 16, push 0xAA with ack high -> one overflow pulse next cycle; 0xAA never emerges; used=15.
REQ-033 SHALL cover: empty FIFO, ack=1 for 2 cycles -> two consecutive underflow pulses; used stays 0.
REQ-034 SHALL cover: used=8, push and pop together for 20 cycles -> used stays 8, output order preserved across pointer wrap.
REQ-035 SHALL cover: used=5, clear and push together -> used=0, valid=0 next cycle, no error pulses; override=1 with used=0 -> stall=1.
REQ-036 SHALL cover, with HWM_EN: peak 11, drain to 3 -> hwm=11; hwm_clr -> hwm=3. Without HWM_EN -> hwm=0 throughout.
